// File: rtl/freq_div_ctrl_if.sv
// Ratio-change request channel into freq_div_ctrl.
// A request transfers on every rising clock edge where req_valid and req_ready are both 1; the master holds req_ratio stable while req_valid is high.
interface freq_div_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             req_valid;
    logic [WIDTH-1:0] req_ratio;
    logic             req_ready;

    modport master (output req_valid, output req_ratio, input req_ready);
    modport slave  (input req_valid, input req_ratio, output req_ready);
endinterface

// File: rtl/freq_div_ctrl.sv
// Owns the divider's ratio and enable. Ratio changes are accepted over a valid/ready channel and,
// while running, land on a rising edge of the fed-back divided clock (or after a timeout), then settle.
module freq_div_ctrl #(
    parameter int WIDTH         = 3,
    parameter int DEFAULT_RATIO = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             en_req,
    freq_div_ctrl_if.slave   req,
    input  logic             clk_div_in,
    output logic [WIDTH-1:0] div_ratio,
    output logic             clk_en,
    output logic             busy,
    output logic             ratio_applied,
    output logic             err_ratio,
    output logic [1:0]       state_dbg
);
    localparam int TIMEOUT_LIMIT = 2 * (2 ** WIDTH);
    localparam int CW = (WIDTH + 2 > $clog2(SETTLE_CYCLES + 1)) ? WIDTH + 2 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_LIMIT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RUN       = 2'd1,
        WAIT_EDGE = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend_ratio;
    logic [CW-1:0]    cnt;
    logic             hist;
    logic [WIDTH-1:0] ratio_in;
    logic             fire;
    logic             legal;
    logic             div_edge;

    assign ratio_in      = req.req_ratio;
    assign req.req_ready = (state == OFF) || (state == RUN);
    assign fire          = req.req_valid && req.req_ready;
    assign legal         = (ratio_in > WIDTH'(1));
    assign div_edge      = clk_div_in && !hist;
    assign state_dbg     = state;

    always_ff @(posedge clk_ref) begin
        ratio_applied <= 1'b0;
        err_ratio     <= 1'b0;
        if (!rst_n) begin
            state      <= OFF;
            div_ratio  <= WIDTH'(DEFAULT_RATIO);
            pend_ratio <= WIDTH'(DEFAULT_RATIO);
            clk_en     <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            hist       <= 1'b0;
        end else begin
            hist <= clk_div_in;
            case (state)
                OFF: begin
                    if (fire && !legal) begin
                        err_ratio <= 1'b1;
                    end else if (fire) begin
                        div_ratio     <= ratio_in;
                        ratio_applied <= 1'b1;
                    end
                    if (en_req) begin
                        state  <= RUN;
                        clk_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (fire && !legal) begin
                        err_ratio <= 1'b1;
                    end else if (fire && (ratio_in == div_ratio)) begin
                        ratio_applied <= 1'b1;
                    end else if (fire && !en_req) begin
                        // Divider is being stopped anyway, so no need to wait for an edge.
                        div_ratio     <= ratio_in;
                        ratio_applied <= 1'b1;
                    end else if (fire) begin
                        pend_ratio <= ratio_in;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= WAIT_EDGE;
                    end
                    if (!en_req) begin
                        state  <= OFF;
                        clk_en <= 1'b0;
                    end
                end
                WAIT_EDGE: begin
                    cnt <= cnt + 1'b1;
                    if (!en_req) begin
                        div_ratio     <= pend_ratio;
                        ratio_applied <= 1'b1;
                        clk_en        <= 1'b0;
                        busy          <= 1'b0;
                        cnt           <= '0;
                        state         <= OFF;
                    end else if (div_edge || (cnt == TIMEOUT_LAST)) begin
                        div_ratio     <= pend_ratio;
                        ratio_applied <= 1'b1;
                        cnt           <= '0;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (!en_req) begin
                        clk_en <= 1'b0;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= OFF;
                    end else if (cnt == SETTLE_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                default: state <= OFF;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_freq_div_ctrl;
    localparam int W      = 3;
    localparam int SETTLE = 2;
    localparam int TMO    = 2 * (2 ** W);

    logic         clk_ref = 1'b0;
    logic         rst_n;
    logic         en_req;
    logic         clk_div_in;
    logic [W-1:0] div_ratio;
    logic         clk_en;
    logic         busy;
    logic         ratio_applied;
    logic         err_ratio;
    logic [1:0]   state_dbg;

    freq_div_ctrl_if #(.WIDTH(W)) bus ();

    freq_div_ctrl #(.WIDTH(W), .DEFAULT_RATIO(2), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_ref      (clk_ref),
        .rst_n        (rst_n),
        .en_req       (en_req),
        .req          (bus),
        .clk_div_in   (clk_div_in),
        .div_ratio    (div_ratio),
        .clk_en       (clk_en),
        .busy         (busy),
        .ratio_applied(ratio_applied),
        .err_ratio    (err_ratio),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk_ref = ~clk_ref;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 off, 1 run, 2 waiting for divided-clock edge, 3 settling
    int cyc = 0;
    int m_mode, m_ratio, m_pend, t_acc, t_app;
    bit m_en, m_busy, m_applied, m_err, m_hist, m_hs, m_edge;
    bit model_live = 0;

    always @(posedge clk_ref) begin
        cyc++;
        m_hs      = bus.req_valid && (m_mode <= 1);
        m_edge    = clk_div_in && !m_hist;
        m_applied = 0;
        m_err     = 0;
        if (!rst_n) begin
            m_mode = 0; m_ratio = 2; m_pend = 2; m_en = 0; m_busy = 0; m_hist = 0;
            exp_q.delete();
        end else begin
            m_hist = clk_div_in;
            if (m_mode == 0) begin
                if (m_hs && bus.req_ratio < 2) m_err = 1;
                else if (m_hs) begin m_ratio = bus.req_ratio; m_applied = 1; end
                if (en_req) begin m_mode = 1; m_en = 1; end
            end else if (m_mode == 1) begin
                if (m_hs) begin
                    if (bus.req_ratio < 2) m_err = 1;
                    else if (bus.req_ratio == m_ratio) m_applied = 1;
                    else if (!en_req) begin m_ratio = bus.req_ratio; m_applied = 1; end
                    else begin m_pend = bus.req_ratio; t_acc = cyc; m_busy = 1; m_mode = 2; end
                end
                if (!en_req) begin m_mode = 0; m_en = 0; end
            end else if (m_mode == 2) begin
                if (!en_req) begin
                    m_ratio = m_pend; m_applied = 1; m_en = 0; m_busy = 0; m_mode = 0;
                end else if (m_edge || (cyc - t_acc == TMO)) begin
                    m_ratio = m_pend; m_applied = 1; t_app = cyc; m_mode = 3;
                end
            end else begin
                if (!en_req) begin m_en = 0; m_busy = 0; m_mode = 0; end
                else if (cyc - t_app == SETTLE) begin m_busy = 0; m_mode = 1; end
            end
        end
        if (m_applied) exp_q.push_back(W'(m_ratio));
        model_live = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_ref) begin
        if (model_live) begin
            check("div_ratio", div_ratio, m_ratio);
            check("clk_en", clk_en, m_en);
            check("busy", busy, m_busy);
            check("ratio_applied", ratio_applied, m_applied);
            check("err_ratio", err_ratio, m_err);
            check("req_ready", bus.req_ready, (m_mode <= 1));
            check("state", state_dbg, m_mode);
            if (ratio_applied === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL applied_queue: got pulse with ratio %0d expected no pulse at %0t", div_ratio, $time);
                end else begin
                    check("applied_value", div_ratio, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int r);
        bit done = 0;
        bus.req_valid = 1'b1;
        bus.req_ratio = W'(r);
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.req_ready) done = 1;
            @(negedge clk_ref);
        end
        bus.req_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: got no handshake for ratio %0d expected one within 40 cycles", r);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_ref);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        en_req = 1'($urandom_range(0, 1));
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_ratio = W'($urandom_range(0, 7));
        clk_div_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_ref);
            en_req = 1'($urandom_range(0, 1));
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_ratio = W'($urandom_range(0, 7));
            clk_div_in = 1'($urandom_range(0, 1));
        end
        check("rst_div_ratio", div_ratio, 2);
        check("rst_clk_en", clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_pulses", {ratio_applied, err_ratio}, 0);
        en_req = 0; bus.req_valid = 0; clk_div_in = 0; rst_n = 1'b1;
        cycles(1);

        // OFF update then enable
        send(6);
        check("off_div_ratio", div_ratio, 6);
        check("off_applied", ratio_applied, 1);
        en_req = 1;
        cycles(1);
        check("enable_clk_en", clk_en, 1);
        check("enable_single_pulse", ratio_applied, 0);

        // Edge-aligned change 6 -> 4
        send(4);
        check("edge_busy", busy, 1);
        check("edge_ready_low", bus.req_ready, 0);
        cycles(3);
        check("edge_hold_ratio", div_ratio, 6);
        clk_div_in = 1;
        cycles(1);
        check("edge_new_ratio", div_ratio, 4);
        check("edge_applied", ratio_applied, 1);
        cycles(1);
        check("settle_busy", busy, 1);
        cycles(1);
        check("settle_done_busy", busy, 0);
        check("settle_done_ready", bus.req_ready, 1);
        clk_div_in = 0;

        // Timeout fallback
        send(3);
        cycles(TMO - 1);
        check("tmo_hold_ratio", div_ratio, 4);
        cycles(1);
        check("tmo_new_ratio", div_ratio, 3);
        check("tmo_applied", ratio_applied, 1);
        cycles(SETTLE);
        check("tmo_ready", bus.req_ready, 1);

        // Illegal and no-op requests at ratio 4
        send(4);
        clk_div_in = 1;
        cycles(1);
        clk_div_in = 0;
        cycles(3);
        check("ratio4", div_ratio, 4);
        send(0);
        check("illegal0_err", err_ratio, 1);
        send(1);
        check("illegal1_err", err_ratio, 1);
        check("illegal1_no_apply", ratio_applied, 0);
        send(4);
        check("noop_applied", ratio_applied, 1);
        check("noop_err", err_ratio, 0);
        check("noop_state_run", state_dbg, 1);
        check("noop_ratio", div_ratio, 4);

        // Disable mid-change
        send(5);
        en_req = 0;
        cycles(1);
        check("dis_ratio", div_ratio, 5);
        check("dis_clk_en", clk_en, 0);
        check("dis_busy", busy, 0);
        check("dis_state_off", state_dbg, 0);

        // Reset mid-change
        en_req = 1;
        cycles(1);
        send(7);
        rst_n = 0;
        cycles(1);
        check("rstmid_ratio", div_ratio, 2);
        check("rstmid_clk_en", clk_en, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_ready", bus.req_ready, 1);
        check("rstmid_state", state_dbg, 0);
        rst_n = 1;

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) en_req = ~en_req;
            if ($urandom_range(0, 5) == 0) clk_div_in = ~clk_div_in;
            bus.req_valid = ($urandom_range(0, 2) == 0);
            bus.req_ratio = W'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 149) != 0);
            cycles(1);
        end
        bus.req_valid = 0;
        rst_n = 1;
        cycles(2);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Control stage directly upstream of the clock frequency divider, clocked by the same reference clock. It owns the divider's `div_ratio` and `clk_en` inputs and accepts ratio-change requests over a valid/ready handshake. It rejects illegal ratios, and while the divider runs it applies a new ratio only on a rising edge of the divided clock (fed back as `clk_div_in`), with a timeout fallback. It then holds off further changes for a settle window.

## Interface
- `WIDTH`, 3: width of ratio fields.
- `DEFAULT_RATIO`, 2: `div_ratio` value after reset; must be >= 2.
- `SETTLE_CYCLES`, 2: `clk_ref` cycles held in SETTLE after a ratio update; must be >= 1.
- `clk_ref`  in  1  reference clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en_req`  in  1  level; 1 requests the divider to run.
- `req_valid`  in  1  ratio request valid.
- `req_ratio`  in  WIDTH  requested division ratio.
- `req_ready`  out  1  request can be accepted this cycle.
- `clk_div_in`  in  1  divider output, fed back; synchronous to `clk_ref`.
- `div_ratio`  out  WIDTH  registered ratio driven to the divider.
- `clk_en`  out  1  registered divider enable.
- `busy`  out  1  a ratio change is pending or settling.
- `ratio_applied`  out  1  1-cycle pulse in the cycle `div_ratio` takes a new accepted value, or on an accepted no-op request.
- `err_ratio`  out  1  1-cycle pulse when an accepted request is rejected as illegal.

## Operation
- Reset values: state OFF, `div_ratio`=DEFAULT_RATIO, `clk_en`=0, `busy`=0, `ratio_applied`=0, `err_ratio`=0, pending ratio=DEFAULT_RATIO, timeout counter=0, edge-history register=0.
- `req_ready` is 1 in OFF and RUN, and 0 in WAIT_EDGE and SETTLE. It is derived combinationally from the state.
- A handshake fires on any cycle with `req_valid` & `req_ready` = 1.
- Illegal ratio: `req_ratio` < 2.
  - The handshake completes.
  - `err_ratio` pulses.
  - No other change.
- Edge detect: the history register samples `clk_div_in` every cycle. An edge is `clk_div_in` & ~history.
- Timeout limit is 2·2^WIDTH cycles.
- OFF:
  - `clk_en`=0.
  - A legal request is written into `div_ratio` directly and `ratio_applied` pulses.
  - `en_req`=1 moves to RUN and sets `clk_en`=1.
- RUN:
  - `clk_en`=1.
  - A legal request equal to the current `div_ratio` is a no-op: `ratio_applied` pulses and the state stays RUN.
  - Any other legal request latches the pending ratio, clears the counter, sets `busy`=1 and moves to WAIT_EDGE.
  - `en_req`=0 clears `clk_en` and moves to OFF.
- WAIT_EDGE:
  - The counter increments every cycle.
  - An edge, or the counter reaching the timeout limit, loads `div_ratio` from the pending ratio, pulses `ratio_applied`, clears the counter and moves to SETTLE.
  - `en_req`=0 takes priority over both. It applies the pending ratio immediately, pulses `ratio_applied`, clears `clk_en` and `busy`, and moves to OFF.
- SETTLE:
  - The counter increments every cycle.
  - At SETTLE_CYCLES−1 the counter clears, `busy` clears and the state moves to RUN.
  - `en_req`=0 clears `clk_en` and `busy` and moves to OFF.
- Simultaneous `en_req` change and handshake in OFF or RUN: the request is processed under the current state's rules. A differing legal ratio accepted in RUN while `en_req`=0 is applied immediately as in OFF and the state moves to OFF.
- Reset asserted mid-operation: returns to the reset values at the next edge. Any pending ratio is discarded.

## Timing
- All outputs except `req_ready` are registered.
- OFF: a handshake at edge N gives the new `div_ratio` and the `ratio_applied` pulse in cycle N+1.
- OFF→RUN: `en_req` sampled high at edge N gives `clk_en`=1 from cycle N+1.
- RUN: a handshake at edge N gives WAIT_EDGE, `busy`=1 and `req_ready`=0 from cycle N+1.
- WAIT_EDGE: an edge sampled at edge M gives the new `div_ratio`, the `ratio_applied` pulse and SETTLE from cycle M+1.
- Worst-case apply latency is the timeout limit plus 1 cycle after acceptance. With WIDTH=3 that is 16+1 cycles.
- SETTLE lasts exactly SETTLE_CYCLES cycles. `req_ready` returns to 1 in the cycle after.
- `err_ratio` and `ratio_applied` never assert together and never last longer than 1 cycle.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with random inputs -> `div_ratio`=2, `clk_en`=0, `busy`=0, `req_ready`=1, no pulses.
- **OFF update then enable:** in OFF, send ratio 6, then raise `en_req` -> `div_ratio`=6 one cycle after the handshake, `ratio_applied` pulses once, `clk_en`=1 one cycle after `en_req` is sampled.
- **Edge-aligned change:** in RUN at ratio 6, request 4 while `clk_div_in` is held low, then raise `clk_div_in` at cycle 5 -> `div_ratio` stays 6 through the edge cycle, then becomes 4; `busy` stays 1 for the 2 SETTLE cycles; `req_ready`=1 after.
- **Timeout:** in RUN, request 3 with `clk_div_in` held low -> `div_ratio`=3 exactly 17 cycles after acceptance, followed by SETTLE.
- **Illegal and no-op requests:** in RUN at ratio 4, request 0, then 1, then 4 -> `err_ratio` pulses twice, then `ratio_applied` pulses once; state stays RUN and `div_ratio` stays 4.
- **Disable mid-change and reset mid-change:**
  - In WAIT_EDGE with 5 pending, drop `en_req` -> next cycle `div_ratio`=5, `clk_en`=0, `busy`=0, state OFF.
  - Repeat the request, then assert `rst_n`=0 -> next cycle `div_ratio`=2 and all reset values restored.
